// File: rtl/axi_w_order_ctrl.sv
// ---------------------------------------------------------------------------
// axi_w_order_ctrl
//
// Purpose:
//   Merges the AXI W channels of several requesters onto a single W stream.
//   The upstream AW arbiter reports every grant it issues; the granted index
//   is queued in an order FIFO. The entry at the FIFO head selects which
//   requester's W beats are passed through, so the W stream follows AW order.
//   The W path is purely combinational and stores no beats. The head entry is
//   retired on the last-beat handshake.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   test_en_i            test mode strap, no functional effect
//   aw_grant_valid_i     an AW grant was issued upstream
//   aw_grant_idx_i       index of the granted requester
//   aw_grant_ready_o     order FIFO has room for another grant
//   slave_*_i/o          per-requester W channels, port p at slice p
//   master_*_o/i         merged W channel toward the W buffer
//   outstanding_o        number of queued grants, including the active one
//   burst_active_o       head burst has moved at least one beat, not the last
// ---------------------------------------------------------------------------
module axi_w_order_ctrl #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int FIFO_DEPTH = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             test_en_i,
    input  logic                             aw_grant_valid_i,
    input  logic [IDX_WIDTH-1:0]             aw_grant_idx_i,
    output logic                             aw_grant_ready_o,
    input  logic [NUM_PORTS-1:0]             slave_valid_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  slave_data_i,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0]  slave_strb_i,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  slave_user_i,
    input  logic [NUM_PORTS-1:0]             slave_last_i,
    output logic [NUM_PORTS-1:0]             slave_ready_o,
    output logic                             master_valid_o,
    output logic [DATA_WIDTH-1:0]            master_data_o,
    output logic [STRB_WIDTH-1:0]            master_strb_o,
    output logic [USER_WIDTH-1:0]            master_user_o,
    output logic                             master_last_o,
    input  logic                             master_ready_i,
    output logic [CNT_WIDTH-1:0]             outstanding_o,
    output logic                             burst_active_o
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [IDX_WIDTH:0]   PORT_LIMIT = (IDX_WIDTH + 1)'(NUM_PORTS);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } burst_state_e;

    logic [IDX_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [IDX_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    burst_state_e         state_q, state_d;

    logic                 fifo_empty;
    logic [IDX_WIDTH-1:0] head_idx;
    logic                 head_ok;
    logic                 push;
    logic                 beat_hs;
    logic                 pop;

    // The test strap has no functional meaning here.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    assign fifo_empty = (cnt_q == '0);
    assign head_idx   = fifo_q[rd_ptr_q];
    // An out-of-range index at the head blocks the W path until reset.
    assign head_ok    = !fifo_empty && ({1'b0, head_idx} < PORT_LIMIT);

    // A full FIFO refuses a grant even if the head retires in the same cycle,
    // which keeps ready independent of the W handshake.
    assign aw_grant_ready_o = (cnt_q != FULL_CNT);
    assign push             = aw_grant_valid_i && aw_grant_ready_o;
    assign beat_hs          = master_valid_o && master_ready_i;
    assign pop              = beat_hs && master_last_o;

    assign outstanding_o  = cnt_q;
    assign burst_active_o = (state_q == ST_BURST);

    // W pass-through mux. Only the head requester sees master ready; every
    // other requester is held off, so their beats wait in place.
    always_comb begin
        master_valid_o = 1'b0;
        master_data_o  = '0;
        master_strb_o  = '0;
        master_user_o  = '0;
        master_last_o  = 1'b0;
        slave_ready_o  = '0;
        if (head_ok) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (head_idx == IDX_WIDTH'(p)) begin
                    master_valid_o   = slave_valid_i[p];
                    master_data_o    = slave_data_i[p*DATA_WIDTH +: DATA_WIDTH];
                    master_strb_o    = slave_strb_i[p*STRB_WIDTH +: STRB_WIDTH];
                    master_user_o    = slave_user_i[p*USER_WIDTH +: USER_WIDTH];
                    master_last_o    = slave_last_i[p];
                    slave_ready_o[p] = master_ready_i;
                end
            end
        end
    end

    // Order FIFO next-state. Pointers wrap naturally because the depth is a
    // power of two. A push into an empty FIFO only becomes the head after the
    // clock edge, so the new grant is served from the following cycle.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = aw_grant_idx_i;
            wr_ptr_d         = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Burst tracker: any beat handshake moves into or out of a burst
    // depending on whether it carried last.
    always_comb begin
        state_d = state_q;
        if (beat_hs) begin
            state_d = master_last_o ? ST_IDLE : ST_BURST;
        end
    end

    // State registers. Reset drops any partially transferred burst and every
    // queued grant at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_axi_w_order_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_w_order_ctrl
//
// Purpose:
//   Self-checking bench for axi_w_order_ctrl. A reference model keeps the
//   queued grants as a list and the requesters' pending beats as per-port
//   lists; expected outputs follow from the list heads. The merged stream is
//   collected and compared against the beats listed in grant order.
// ---------------------------------------------------------------------------
module tb_axi_w_order_ctrl;

    localparam int NP     = 2;
    localparam int DW     = 64;
    localparam int UW     = 6;
    localparam int DEPTH  = 4;
    localparam int SW     = DW / 8;
    localparam int IW     = 1;
    localparam int CW     = 3;
    localparam int CTRL_W = NP + CW + 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             test_en;
    logic             aw_grant_valid;
    logic [IW-1:0]    aw_grant_idx;
    logic             aw_grant_ready;
    logic [NP-1:0]    slave_valid;
    logic [NP*DW-1:0] slave_data;
    logic [NP*SW-1:0] slave_strb;
    logic [NP*UW-1:0] slave_user;
    logic [NP-1:0]    slave_last;
    logic [NP-1:0]    slave_ready;
    logic             master_valid;
    logic [DW-1:0]    master_data;
    logic [SW-1:0]    master_strb;
    logic [UW-1:0]    master_user;
    logic             master_last;
    logic             master_ready;
    logic [CW-1:0]    outstanding;
    logic             burst_active;

    axi_w_order_ctrl #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .test_en_i        (test_en),
        .aw_grant_valid_i (aw_grant_valid),
        .aw_grant_idx_i   (aw_grant_idx),
        .aw_grant_ready_o (aw_grant_ready),
        .slave_valid_i    (slave_valid),
        .slave_data_i     (slave_data),
        .slave_strb_i     (slave_strb),
        .slave_user_i     (slave_user),
        .slave_last_i     (slave_last),
        .slave_ready_o    (slave_ready),
        .master_valid_o   (master_valid),
        .master_data_o    (master_data),
        .master_strb_o    (master_strb),
        .master_user_o    (master_user),
        .master_last_o    (master_last),
        .master_ready_i   (master_ready),
        .outstanding_o    (outstanding),
        .burst_active_o   (burst_active)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed control outputs and merged beat as single vectors.
    logic [CTRL_W-1:0] ctrl_act;
    beat_t             beat_act;
    assign ctrl_act = {master_valid, slave_ready, aw_grant_ready, outstanding, burst_active};
    assign beat_act = {master_data, master_strb, master_user, master_last};

    // Reference model state and stimulus bookkeeping.
    beat_t             port_beats [NP][$];
    int                pend_q[$];
    int                ord_q[$];
    bit                mdl_burst;
    beat_t             exp_stream[$];
    beat_t             obs_stream[$];
    beat_t             drv_beat [NP];
    logic [NP-1:0]     valid_en;
    bit                grant_en;
    logic              exp_valid;
    beat_t             exp_beat;
    logic [CTRL_W-1:0] ctrl_exp;
    int                compared;
    int                mismatched;
    int                cycle_no;

    // Queue a grant for a port and the burst that goes with it.
    task automatic add_grant(input int port, input int len);
        beat_t b;
        pend_q.push_back(port);
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom(), $urandom()};
            b.strb = SW'($urandom());
            b.user = UW'($urandom());
            b.last = (i == len - 1);
            port_beats[port].push_back(b);
            exp_stream.push_back(b);
        end
    endtask

    function automatic bit drained();
        bit d;
        d = (ord_q.size() == 0) && (pend_q.size() == 0);
        for (int p = 0; p < NP; p++) begin
            if (port_beats[p].size() != 0) d = 1'b0;
        end
        return d;
    endfunction

    // Drive every requester from its beat list, offer the next pending grant,
    // and derive the expected outputs from the model's queued grants.
    task automatic drive_inputs();
        int            h;
        logic [NP-1:0] sr;
        for (int p = 0; p < NP; p++) begin
            if (port_beats[p].size() > 0) begin
                drv_beat[p]    = port_beats[p][0];
                slave_valid[p] = valid_en[p];
            end else begin
                drv_beat[p]    = '0;
                slave_valid[p] = 1'b0;
            end
            slave_data[p*DW +: DW] = drv_beat[p].data;
            slave_strb[p*SW +: SW] = drv_beat[p].strb;
            slave_user[p*UW +: UW] = drv_beat[p].user;
            slave_last[p]          = drv_beat[p].last;
        end
        aw_grant_valid = grant_en && (pend_q.size() > 0);
        aw_grant_idx   = (pend_q.size() > 0) ? IW'(pend_q[0]) : '0;
        exp_valid = 1'b0;
        exp_beat  = '0;
        sr        = '0;
        if (ord_q.size() > 0) begin
            h         = ord_q[0];
            exp_valid = slave_valid[h];
            exp_beat  = drv_beat[h];
            sr[h]     = master_ready;
        end
        ctrl_exp = {exp_valid, sr, (ord_q.size() != DEPTH), CW'(ord_q.size()), mdl_burst};
    endtask

    // Record the DUT's transfer, advance the model by one clock, and move to
    // just after the next rising edge.
    task automatic advance();
        bit hs;
        bit push;
        int h;
        if (master_valid && master_ready) begin
            obs_stream.push_back(beat_act);
        end
        hs   = exp_valid && master_ready;
        push = aw_grant_valid && (ord_q.size() != DEPTH);
        if (hs) begin
            h = ord_q[0];
            void'(port_beats[h].pop_front());
            mdl_burst = !exp_beat.last;
            if (exp_beat.last) void'(ord_q.pop_front());
        end
        if (push) begin
            ord_q.push_back(pend_q[0]);
            void'(pend_q.pop_front());
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic clear_model();
        ord_q.delete();
        pend_q.delete();
        for (int p = 0; p < NP; p++) port_beats[p].delete();
        exp_stream.delete();
        obs_stream.delete();
        mdl_burst = 1'b0;
    endtask

    // Reset behaviour, including that a grant held during reset is only
    // taken on the first edge with reset released.
    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n          = 1'b1;
        master_ready   = 1'b1;
        slave_valid    = '1;
        slave_last     = '0;
        slave_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
        slave_strb     = '1;
        slave_user     = '1;
        aw_grant_valid = 1'b1;
        aw_grant_idx   = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (ctrl_act !== {1'b0, NP'(0), 1'b1, CW'(0), 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %h want %h", ctrl_act, {1'b0, NP'(0), 1'b1, CW'(0), 1'b0});
        end
        compared++;
        if (beat_act !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_beat: got %h want 0", beat_act);
        end
        #2 rst_n = 1'b1;
        #1;
        compared++;
        if (outstanding !== CW'(0)) begin
            mismatched++;
            $display("[TB] FAIL release_no_early_push: got %0d want 0", outstanding);
        end
        @(posedge clk);
        #1;
        compared++;
        if (ctrl_act !== {1'b1, NP'(1), 1'b1, CW'(1), 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL first_push_after_release: got %h want %h", ctrl_act, {1'b1, NP'(1), 1'b1, CW'(1), 1'b0});
        end
        aw_grant_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        compared++;
        if (ctrl_act !== {1'b0, NP'(0), 1'b1, CW'(0), 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL async_reset_clear: got %h want %h", ctrl_act, {1'b0, NP'(0), 1'b1, CW'(0), 1'b0});
        end
        slave_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
    endtask

    // Grants 1 then 0; port 1 sends 3 beats and port 0 sends 2, both valid
    // throughout. Port 1's burst must come out first.
    task automatic test_order();
        int c;
        $display("[TB] test_order");
        valid_en     = '1;
        grant_en     = 1'b1;
        master_ready = 1'b1;
        add_grant(1, 3);
        add_grant(0, 2);
        for (c = 0; c < 20 && !drained(); c++) begin
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL order_ctrl c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            compared++;
            if (beat_act !== exp_beat) begin
                mismatched++;
                $display("[TB] FAIL order_beat c%0d: got %h want %h", c, beat_act, exp_beat);
            end
            advance();
        end
        compared++;
        if (!drained() || obs_stream.size() != 5) begin
            mismatched++;
            $display("[TB] FAIL order_count: got %0d beats want 5", obs_stream.size());
        end
        for (int i = 0; i < obs_stream.size() && i < exp_stream.size(); i++) begin
            compared++;
            if (obs_stream[i] !== exp_stream[i]) begin
                mismatched++;
                $display("[TB] FAIL order_stream[%0d]: got %h want %h", i, obs_stream[i], exp_stream[i]);
            end
        end
        clear_model();
    endtask

    // Fill the order FIFO with no W traffic, hold a fifth grant, then retire
    // the head while the fifth grant is still offered.
    task automatic test_full();
        $display("[TB] test_full");
        valid_en     = '0;
        grant_en     = 1'b1;
        master_ready = 1'b1;
        for (int i = 0; i < 5; i++) add_grant(i % 2, 1);
        for (int c = 0; c < 6; c++) begin
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL full_fill c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            advance();
        end
        valid_en[0] = 1'b1;
        drive_inputs();
        @(negedge clk);
        compared++;
        if ({outstanding, aw_grant_ready, master_valid, master_last} !== {CW'(4), 3'b011}) begin
            mismatched++;
            $display("[TB] FAIL full_pop_cycle: got %h want %h", {outstanding, aw_grant_ready, master_valid, master_last}, {CW'(4), 3'b011});
        end
        advance();
        drive_inputs();
        @(negedge clk);
        compared++;
        if ({outstanding, aw_grant_ready} !== {CW'(3), 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL full_after_pop: got %h want %h", {outstanding, aw_grant_ready}, {CW'(3), 1'b1});
        end
        advance();
        drive_inputs();
        @(negedge clk);
        compared++;
        if ({outstanding, aw_grant_ready} !== {CW'(4), 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL full_refill: got %h want %h", {outstanding, aw_grant_ready}, {CW'(4), 1'b0});
        end
        advance();
        valid_en = '1;
        for (int c = 0; c < 20 && !drained(); c++) begin
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL full_drain c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            advance();
        end
        compared++;
        if (!drained() || obs_stream.size() != 5) begin
            mismatched++;
            $display("[TB] FAIL full_count: got %0d beats want 5", obs_stream.size());
        end
        for (int i = 0; i < obs_stream.size() && i < exp_stream.size(); i++) begin
            compared++;
            if (obs_stream[i] !== exp_stream[i]) begin
                mismatched++;
                $display("[TB] FAIL full_stream[%0d]: got %h want %h", i, obs_stream[i], exp_stream[i]);
            end
        end
        clear_model();
    endtask

    // Master ready alternates during a 3-beat burst; burst_active must hold
    // across the stall cycles.
    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        valid_en = '1;
        grant_en = 1'b1;
        add_grant(0, 3);
        for (int c = 0; c < 20 && !drained(); c++) begin
            master_ready = (c % 2 == 1);
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL bp_ctrl c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            if (c == 2 || c == 4) begin
                compared++;
                if ({burst_active, master_valid, slave_ready} !== {2'b11, NP'(0)}) begin
                    mismatched++;
                    $display("[TB] FAIL bp_stall c%0d: got %h want %h", c, {burst_active, master_valid, slave_ready}, {2'b11, NP'(0)});
                end
            end
            advance();
        end
        compared++;
        if (!drained() || obs_stream.size() != 3 || burst_active !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_count: got %0d beats burst %b want 3 beats burst 0", obs_stream.size(), burst_active);
        end
        for (int i = 0; i < obs_stream.size() && i < exp_stream.size(); i++) begin
            compared++;
            if (obs_stream[i] !== exp_stream[i]) begin
                mismatched++;
                $display("[TB] FAIL bp_stream[%0d]: got %h want %h", i, obs_stream[i], exp_stream[i]);
            end
        end
        master_ready = 1'b1;
        clear_model();
    endtask

    // Reset in the middle of a 4-beat burst, then a clean 1-beat burst.
    task automatic test_reset_mid_burst();
        int c;
        $display("[TB] test_reset_mid_burst");
        valid_en     = '1;
        grant_en     = 1'b1;
        master_ready = 1'b1;
        add_grant(1, 4);
        for (c = 0; c < 10 && obs_stream.size() < 2; c++) begin
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL mid_ctrl c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            advance();
        end
        drive_inputs();
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (ctrl_act !== {1'b0, NP'(0), 1'b1, CW'(0), 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_ctrl: got %h want %h", ctrl_act, {1'b0, NP'(0), 1'b1, CW'(0), 1'b0});
        end
        compared++;
        if (beat_act !== '0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_beat: got %h want 0", beat_act);
        end
        clear_model();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_grant(0, 1);
        for (c = 0; c < 10 && !drained(); c++) begin
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL mid_after c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            advance();
        end
        compared++;
        if (!drained() || obs_stream.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL mid_after_count: got %0d beats want 1", obs_stream.size());
        end
        for (int i = 0; i < obs_stream.size() && i < exp_stream.size(); i++) begin
            compared++;
            if (obs_stream[i] !== exp_stream[i]) begin
                mismatched++;
                $display("[TB] FAIL mid_after_stream[%0d]: got %h want %h", i, obs_stream[i], exp_stream[i]);
            end
        end
        clear_model();
    endtask

    // Six single-beat bursts on alternating ports must go out one per cycle.
    task automatic test_back_to_back();
        int first_c;
        int last_c;
        int n;
        $display("[TB] test_back_to_back");
        valid_en     = '1;
        grant_en     = 1'b1;
        master_ready = 1'b1;
        first_c      = -1;
        last_c       = -1;
        for (int i = 0; i < 6; i++) add_grant(i % 2, 1);
        for (int c = 0; c < 30 && !drained(); c++) begin
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL b2b_ctrl c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            n = obs_stream.size();
            advance();
            if (obs_stream.size() > n) begin
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        compared++;
        if (obs_stream.size() != 6 || (last_c - first_c) != 5) begin
            mismatched++;
            $display("[TB] FAIL b2b_rate: got %0d beats over %0d cycles want 6 over 6", obs_stream.size(), last_c - first_c + 1);
        end
        for (int i = 0; i < obs_stream.size() && i < exp_stream.size(); i++) begin
            compared++;
            if (obs_stream[i] !== exp_stream[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_stream[%0d]: got %h want %h", i, obs_stream[i], exp_stream[i]);
            end
        end
        clear_model();
    endtask

    // Random grants, burst lengths, valid gaps and back-pressure.
    task automatic test_random();
        $display("[TB] test_random");
        for (int c = 0; c < 600; c++) begin
            if (c < 400) begin
                if (pend_q.size() < 2 && $urandom_range(0, 2) == 0) begin
                    add_grant($urandom_range(0, NP - 1), $urandom_range(1, 4));
                end
                grant_en     = ($urandom_range(0, 3) != 0);
                valid_en     = NP'($urandom());
                master_ready = ($urandom_range(0, 3) != 0);
            end else begin
                if (drained()) break;
                grant_en     = 1'b1;
                valid_en     = '1;
                master_ready = 1'b1;
            end
            drive_inputs();
            @(negedge clk);
            compared++;
            if (ctrl_act !== ctrl_exp) begin
                mismatched++;
                $display("[TB] FAIL rand_ctrl c%0d: got %h want %h", c, ctrl_act, ctrl_exp);
            end
            compared++;
            if (beat_act !== exp_beat) begin
                mismatched++;
                $display("[TB] FAIL rand_beat c%0d: got %h want %h", c, beat_act, exp_beat);
            end
            advance();
        end
        compared++;
        if (!drained() || obs_stream.size() != exp_stream.size()) begin
            mismatched++;
            $display("[TB] FAIL rand_count: got %0d beats want %0d", obs_stream.size(), exp_stream.size());
        end
        for (int i = 0; i < obs_stream.size() && i < exp_stream.size(); i++) begin
            compared++;
            if (obs_stream[i] !== exp_stream[i]) begin
                mismatched++;
                $display("[TB] FAIL rand_stream[%0d]: got %h want %h", i, obs_stream[i], exp_stream[i]);
            end
        end
        clear_model();
    endtask

    // Test sequence.
    initial begin
        compared       = 0;
        mismatched     = 0;
        cycle_no       = 0;
        mdl_burst      = 1'b0;
        test_en        = 1'b0;
        valid_en       = '0;
        grant_en       = 1'b0;
        master_ready   = 1'b0;
        aw_grant_valid = 1'b0;
        aw_grant_idx   = '0;
        slave_valid    = '0;
        slave_data     = '0;
        slave_strb     = '0;
        slave_user     = '0;
        slave_last     = '0;
        test_reset();
        test_order();
        test_full();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d compared %0d mismatched", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_w_order_ctrl.md
AXI_W_ORDER_CTRL -- requirements
Module: axi_w_order_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_PORTS, 2, number of W-channel requesters (2..8)
- DATA_WIDTH, 64, W data width
- USER_WIDTH, 6, W user width
- FIFO_DEPTH, 4, order-FIFO entries (power of 2, >=2)
- STRB_WIDTH, DATA_WIDTH/8, derived, not overridden
- IDX_WIDTH, max(1,$clog2(NUM_PORTS)), derived, not overridden
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), derived, not overridden
REQ-002 Ports SHALL be:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- test_en_i  in  1  test mode, no functional effect
- aw_grant_valid_i  in  1  AW grant issued upstream
- aw_grant_idx_i  in  IDX_WIDTH  granted requester index
- aw_grant_ready_o  out  1  order FIFO can accept a grant
- slave_valid_i  in  NUM_PORTS  per-port W valid
- slave_data_i  in  NUM_PORTS*DATA_WIDTH  per-port W data, port p at slice p
- slave_strb_i  in  NUM_PORTS*STRB_WIDTH  per-port W strobe
- slave_user_i  in  NUM_PORTS*USER_WIDTH  per-port W user
- slave_last_i  in  NUM_PORTS  per-port W last
- slave_ready_o  out  NUM_PORTS  per-port W ready
- master_valid_o / master_data_o / master_strb_o / master_user_o / master_last_o  out  1/DATA/STRB/USER/1  merged W toward the W buffer
- master_ready_i  in  1  downstream ready
- outstanding_o  out  CNT_WIDTH  grants queued, incl. the active one
- burst_active_o  out  1  at least one beat of head burst transferred, last not yet

Function
REQ-003 Order FIFO SHALL store granted indices in grant order; push on aw_grant_valid_i && aw_grant_ready_o.
REQ-004 aw_grant_ready_o SHALL equal (outstanding_o != FIFO_DEPTH); no push when full, even when a pop occurs in the same cycle.
REQ-005 When FIFO empty: master_valid_o=0, slave_ready_o=all 0, master data/strb/user/last=0.
REQ-006 When non-empty with head index h: master_valid_o=slave_valid_i[h]; master data/strb/user/last = slice h; slave_ready_o[h]=master_ready_i; all other slave_ready_o bits=0.
REQ-007 Path SHALL be combinational, zero-cycle latency, no storage of W beats.
REQ-008 Pop SHALL occur on master_valid_o && master_ready_i && master_last_o; the next head takes effect the following cycle.
REQ-009 Simultaneous push and pop SHALL leave outstanding_o unchanged; a grant pushed into an empty FIFO is served from the next cycle.
REQ-010 burst_active_o SHALL set on a non-last beat handshake and clear on the last-beat handshake.
REQ-011 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 Beats on a non-head port SHALL be stalled (ready=0), never dropped or reordered.
REQ-013 aw_grant_idx_i >= NUM_PORTS SHALL be pushed as-is; when at head, master_valid_o=0 and all slave_ready_o=0 (blocked; upstream responsibility).

Reset
REQ-014 rst_ni low SHALL immediately clear pointers, outstanding_o=0, burst_active_o=0, aw_grant_ready_o=1, all other outputs 0, including mid-burst; partial bursts are discarded.
REQ-015 After rst_ni deassertion the first accepted grant SHALL occur no earlier than the first rising edge with rst_ni high.

Verification
REQ-016 Grants 1,0 then port0 sends 2 beats, port1 sends 3 beats, both valid throughout -> master sees port1 beats 1-3, then port0 beats 1-2; slave_ready_o[0]=0 until the cycle after port1 last.
REQ-017 FIFO_DEPTH=4, push 4 grants, no W traffic -> outstanding_o=4, aw_grant_ready_o=0; fifth grant held; after one last-beat handshake ready returns to 1 next cycle.
REQ-018 Full FIFO with grant valid and last-beat pop in the same cycle -> no push, outstanding_o 4->3.
REQ-019 master_ready_i toggling 1,0,1 during a 3-beat burst -> every beat transferred exactly once, burst_active_o=1 from beat 1 to last, order intact.
REQ-020 rst_ni asserted after beat 2 of a 4-beat burst -> same-cycle outputs 0, outstanding_o=0; after release the new grant 0 plus a 1-beat burst passes normally.
REQ-021 Single-beat bursts back-to-back on alternating ports with 6 grants queued -> one beat per cycle, no bubble between bursts.
